mips_mc_control: RTL and testbench



---
 rtl/mips_mc_pkg.sv | 41 ++++
 rtl/mips_alu_decoder.sv | 18 +
 rtl/mips_mc_control.sv | 123 ++++++++++++
 tb/tb_mips_mc_control.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_mc_pkg.sv
// mips_mc_pkg: state encoding, opcode/funct and ALU control constants for the multicycle MIPS control
package mips_mc_pkg;
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [2:0] AC_ADD = 3'b010;
  localparam logic [2:0] AC_SUB = 3'b110;
  localparam logic [2:0] AC_AND = 3'b000;
  localparam logic [2:0] AC_OR  = 3'b001;
  localparam logic [2:0] AC_SLT = 3'b111;
  function automatic logic is_legal(logic [5:0] op);
    return op == OP_RTYPE || op == OP_LW || op == OP_SW || op == OP_BEQ || op == OP_ADDI || op == OP_J;
  endfunction
endpackage

// File: rtl/mips_alu_decoder.sv
// mips_alu_decoder: maps alu_op and funct to the ALU operation select
module mips_alu_decoder
  import mips_mc_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_control
);
  logic [2:0] funct_ac;
  always_comb begin
    funct_ac = funct == F_SUB ? AC_SUB :
               funct == F_AND ? AC_AND :
               funct == F_OR  ? AC_OR  :
               funct == F_SLT ? AC_SLT : AC_ADD;
    alu_control = alu_op == ALUOP_SUB   ? AC_SUB :
                  alu_op == ALUOP_FUNCT ? funct_ac : AC_ADD;
  end
endmodule

// File: rtl/mips_mc_control.sv
// mips_mc_control: Moore main FSM of the multicycle MIPS CPU driving all datapath selects and enables
module mips_mc_control
  import mips_mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic       mem_to_reg,
  output logic       reg_dest,
  output logic       i_or_d,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [2:0] alu_control,
  output logic       ir_write,
  output logic       mem_write,
  output logic       pc_write,
  output logic       branch,
  output logic       reg_write,
  output logic       illegal_op,
  output logic [3:0] state
);
  state_t     state_q, state_d;
  logic [1:0] alu_op;
  logic [2:0] dec_ac;
  logic       ir_w, mem_w, pc_w, br, reg_w, ill, valid;
  mips_alu_decoder u_alu_dec (
    .alu_op      (alu_op),
    .funct       (funct),
    .alu_control (dec_ac)
  );
  always_comb begin
    state_d    = S_FETCH;
    mem_to_reg = 1'b0;
    reg_dest   = 1'b0;
    i_or_d     = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    alu_op     = ALUOP_ADD;
    ir_w       = 1'b0;
    mem_w      = 1'b0;
    pc_w       = 1'b0;
    br         = 1'b0;
    reg_w      = 1'b0;
    ill        = 1'b0;
    valid      = 1'b1;
    case (state_q)
      S_FETCH: begin
        alu_src_b = 2'b01;
        ir_w      = 1'b1;
        pc_w      = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        ill       = !is_legal(opcode);
        state_d   = (opcode == OP_LW || opcode == OP_SW) ? S_MEMADR :
                    opcode == OP_RTYPE ? S_EXECUTE  :
                    opcode == OP_BEQ   ? S_BRANCH   :
                    opcode == OP_ADDI  ? S_ADDIEXEC :
                    opcode == OP_J     ? S_JUMP     : S_FETCH;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = opcode == OP_SW ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        i_or_d  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_w      = 1'b1;
      end
      S_MEMWR: begin
        i_or_d = 1'b1;
        mem_w  = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dest = 1'b1;
        reg_w    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_src    = 2'b01;
        br        = 1'b1;
      end
      S_ADDIEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: reg_w = 1'b1;
      S_JUMP: begin
        pc_src = 2'b10;
        pc_w   = 1'b1;
      end
      default: valid = 1'b0;
    endcase
  end
  // enables are gated by rst_n so a mid-instruction reset kills writes without waiting for an edge
  assign ir_write    = ir_w & rst_n;
  assign mem_write   = mem_w & rst_n;
  assign pc_write    = pc_w & rst_n;
  assign branch      = br & rst_n;
  assign reg_write   = reg_w & rst_n;
  assign illegal_op  = ill & rst_n;
  assign alu_control = valid ? dec_ac : 3'b000;
  assign state       = state_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end
endmodule

// File: tb/tb_mips_mc_control.sv
// tb_mips_mc_control: per-instruction path model with randomized instruction stream and directed reset checks
module tb_mips_mc_control;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       mem_to_reg, reg_dest, i_or_d, alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_control;
  logic       ir_write, mem_write, pc_write, branch, reg_write, illegal_op;
  logic [3:0] state;
  logic [16:0] dut_vec;
  int compared = 0;
  int mismatched = 0;
  int idx = 0;
  bit chk = 1'b0;

  mips_mc_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
    .mem_to_reg(mem_to_reg), .reg_dest(reg_dest), .i_or_d(i_or_d), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_control(alu_control),
    .ir_write(ir_write), .mem_write(mem_write), .pc_write(pc_write), .branch(branch),
    .reg_write(reg_write), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  assign dut_vec = {mem_to_reg, reg_dest, i_or_d, alu_src_a, alu_src_b, pc_src, alu_control,
                    ir_write, mem_write, pc_write, branch, reg_write, illegal_op};

  // Each instruction is a fixed walk through state codes, starting at FETCH.
  function automatic int path_state(logic [5:0] op, int i);
    int p[$];
    case (op)
      6'b100011: p = '{0, 1, 2, 3, 4};
      6'b101011: p = '{0, 1, 2, 5};
      6'b000000: p = '{0, 1, 6, 7};
      6'b000100: p = '{0, 1, 8};
      6'b000010: p = '{0, 1, 11};
      6'b001000: p = '{0, 1, 9, 10};
      default:   p = '{0, 1};
    endcase
    return (i < p.size()) ? p[i] : -1;
  endfunction

  function automatic int path_len(logic [5:0] op);
    int n = 0;
    while (path_state(op, n) >= 0) n++;
    return n;
  endfunction

  function automatic logic [2:0] ref_alu(logic [5:0] f);
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // {m2r, rdst, iord, asa, asb[2], pcs[2], ac[3], irw, mw, pcw, br, rw, ill}
  function automatic logic [16:0] exp_vec(int s, logic [5:0] op, logic [5:0] f);
    logic ill;
    ill = (path_len(op) == 2);
    case (s)
      0:  return 17'b0000_01_00_010_101000;
      1:  return {11'b0000_11_00_010, 5'b00000, ill};
      2:  return 17'b0001_10_00_010_000000;
      3:  return 17'b0010_00_00_010_000000;
      4:  return 17'b1000_00_00_010_000010;
      5:  return 17'b0010_00_00_010_010000;
      6:  return {8'b0001_00_00, ref_alu(f), 6'b000000};
      7:  return 17'b0100_00_00_010_000010;
      8:  return 17'b0001_00_01_110_000100;
      9:  return 17'b0001_10_00_010_000000;
      10: return 17'b0000_00_00_010_000010;
      11: return 17'b0000_00_10_010_001000;
      default: return 17'b0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) idx = 0;
    else begin
      idx++;
      if (idx >= path_len(opcode)) idx = 0;
    end
  end

  always @(negedge clk) begin
    if (chk) begin
      int es;
      logic [16:0] ev;
      es = rst_n ? path_state(opcode, idx) : 0;
      ev = exp_vec(es, opcode, funct);
      if (!rst_n) ev[5:0] = 6'b0;
      check("cycle_state", {28'b0, state}, es);
      check("cycle_outputs", {15'b0, dut_vec}, {15'b0, ev});
    end
  end

  // Called at #1 after a clock edge with the model in FETCH; returns the observed state walk.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] f, output logic [31:0] trace,
                           output logic [4:0] en_or, output logic [2:0] ac_exec, output int ill_cnt);
    opcode = op;
    funct = f;
    trace = {28'b0, state};
    en_or = 5'b0;
    ac_exec = 3'bxxx;
    ill_cnt = 0;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk);
      #1;
      trace = (trace << 4) | {28'b0, state};
      if (state != 4'd0) en_or |= {ir_write, mem_write, pc_write, branch, reg_write};
      if (state == 4'd6) ac_exec = alu_control;
      if (illegal_op) ill_cnt++;
      if (idx == 0) break;
    end
  endtask

  initial begin
    logic [31:0] tr;
    logic [4:0]  eo;
    logic [2:0]  ac;
    int          ic;
    logic [5:0]  fl[6];
    logic [2:0]  al[6];
    logic [5:0]  ops[7];
    fl = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};
    al = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b010};
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010, 6'b001000, 6'b111111};
    chk = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {28'b0, state}, 0);
    check("reset_enables", {26'b0, ir_write, pc_write, mem_write, reg_write, branch, illegal_op}, 0);
    check("reset_alu_src_b", {30'b0, alu_src_b}, 1);
    rst_n = 1'b1;
    run_instr(6'b100011, 6'b0, tr, eo, ac, ic);
    check("lw_trace", tr, 32'h012340);
    check("lw_enables", {27'b0, eo}, 5'b00001);
    run_instr(6'b101011, 6'b0, tr, eo, ac, ic);
    check("sw_trace", tr, 32'h01250);
    check("sw_enables", {27'b0, eo}, 5'b01000);
    for (int i = 0; i < 6; i++) begin
      run_instr(6'b000000, fl[i], tr, eo, ac, ic);
      check("rtype_trace", tr, 32'h01670);
      check("rtype_alu_control", {29'b0, ac}, {29'b0, al[i]});
    end
    run_instr(6'b000100, 6'b0, tr, eo, ac, ic);
    check("beq_trace", tr, 32'h0180);
    check("beq_enables", {27'b0, eo}, 5'b00010);
    run_instr(6'b000010, 6'b0, tr, eo, ac, ic);
    check("j_trace", tr, 32'h01B0);
    check("j_enables", {27'b0, eo}, 5'b00100);
    run_instr(6'b001000, 6'b0, tr, eo, ac, ic);
    check("addi_trace", tr, 32'h019A0);
    check("addi_enables", {27'b0, eo}, 5'b00001);
    run_instr(6'b111111, 6'b0, tr, eo, ac, ic);
    check("illegal_trace", tr, 32'h010);
    check("illegal_enables", {27'b0, eo}, 0);
    check("illegal_cycles", ic, 1);
    // asynchronous reset in the middle of a store
    opcode = 6'b101011;
    repeat (3) @(posedge clk);
    #2;
    check("memwr_before_reset", {30'b0, state == 4'd5, mem_write}, 2'b11);
    rst_n = 1'b0;
    #1;
    check("async_reset_state", {28'b0, state}, 0);
    check("async_reset_mem_write", {31'b0, mem_write}, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_hold_writes", {30'b0, pc_write, ir_write}, 0);
    end
    #2;
    opcode = 6'b000010;
    rst_n = 1'b1;
    #1;
    check("release_fetch_en", {30'b0, pc_write, ir_write}, 2'b11);
    @(posedge clk);
    #1;
    check("release_first_edge", {28'b0, state}, 1);
    for (int k = 0; k < 5 && idx != 0; k++) begin
      @(posedge clk);
      #1;
    end
    check("release_j_done", {28'b0, state}, 0);
    for (int n = 0; n < 200; n++) begin
      int sel;
      logic [5:0] op, f;
      sel = $urandom_range(0, 7);
      op = (sel == 7) ? 6'($urandom) : ops[sel];
      f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fl[$urandom_range(0, 5)];
      run_instr(op, f, tr, eo, ac, ic);
      if (state != 4'd0) check("random_end_fetch", {28'b0, state}, 0);
    end
    chk = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
